save_ram_uploader: RTL
======================

# save_ram_uploader

Serves HPS upload (save) reads of the cartridge SuperChip/extra RAM over the ioctl upload channel. It is the read-direction counterpart of the ROM download path. It sits in `emu` on `clk_sys` between the `hps_io` ioctl upload signals and a request/acknowledge port on the RAM arbiter, so the CPU and the uploader can share the cartridge RAM. It stalls the HPS with `ioctl_wait` until each byte is fetched.

## Interface
Parameters:
- `AW`, 8: RAM address width.
- `SIZE`, 256: number of RAM bytes exposed; addresses `0..SIZE-1` map to RAM.
- `TIMEOUT`, 63: maximum cycles spent waiting for `mem_ack` before a request is abandoned.

Ports:
- `clk_sys`  in  1: system clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `ioctl_upload`  in  1: upload session active.
- `ioctl_rd`  in  1: single-cycle read strobe from HPS.
- `ioctl_addr`  in  25: byte address of the read.
- `ioctl_din`  out  8: returned byte.
- `ioctl_wait`  out  1: HPS stall; high while a read is in progress.
- `mem_req`  out  1: RAM request, held until acknowledged.
- `mem_addr`  out  AW: RAM address; stable while `mem_req` is high.
- `mem_ack`  in  1: arbiter grant; `mem_dout` is valid in the same cycle.
- `mem_dout`  in  8: RAM read data.
- `busy`  out  1: high whenever the state is not IDLE.
- `timeout_err`  out  1: sticky flag; set on any timeout, cleared at session start.

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE. This covers `ioctl_din`, `ioctl_wait`, `mem_req`, `mem_addr`, `busy` and `timeout_err`.
- **Session start:** on the rising edge of `ioctl_upload`, clear `timeout_err` and the checksum. A read accepted on that same edge is valid.
- **States:**
  - IDLE: accepts `ioctl_rd` only when `ioctl_upload=1`.
    - `ioctl_addr < SIZE`: latch `mem_addr = ioctl_addr[AW-1:0]`, go to REQ.
    - Any other address: go to RESP.
  - REQ: `mem_req=1`, and a wait counter increments each cycle.
    - `mem_ack` sampled high: `ioctl_din <= mem_dout`, fold the byte into the checksum, go to IDLE.
    - Counter reaches `TIMEOUT` first: `ioctl_din <= 8'h00`, `timeout_err <= 1`, go to IDLE.
  - RESP: one cycle only.
    - `ioctl_din <= 8'hFF`, or the checksum when enabled and the address equals `SIZE` (see Configuration).
    - Then go to IDLE.
- **Outputs per state:** `ioctl_wait` is 1 in REQ and RESP, 0 in IDLE. `mem_req` is 1 only in REQ.
- **Dropped inputs:**
  - `ioctl_rd` while not in IDLE is ignored.
  - `ioctl_rd` with `ioctl_upload=0` is ignored.
  - `mem_ack` outside REQ is ignored.
- **Upload dropped mid-operation:** `ioctl_upload` sampled low in any state forces IDLE. `mem_req` and `ioctl_wait` are 0 from that edge, and `ioctl_din` holds its value.
- **Address width:** `ioctl_addr` bits above the compare are significant. Any address ≥ `SIZE` (other than the checksum address) returns `8'hFF` and makes no RAM access.

## Timing
- **Read accepted:** `ioctl_rd` sampled at edge E0 sets `ioctl_wait=1` and `busy=1` from E0. `mem_req` and `mem_addr` are also valid from E0 for in-range reads.
- **In-range completion:** `mem_ack` sampled at edge Ek updates `ioctl_din` and clears `mem_req` and `ioctl_wait` at Ek.
  - Minimum wait is 1 cycle (ack in the first REQ cycle).
  - Maximum wait is `TIMEOUT` cycles.
- **Out-of-range / checksum read:** data is updated and `ioctl_wait` falls at E1, so wait is high for exactly 1 cycle.
- **Back-to-back reads:** the next `ioctl_rd` is accepted on the first edge where the state is IDLE.

## Configuration
- **`UPLOAD_CKSUM_EN` defined:**
  - An 8-bit XOR checksum is kept over every byte returned from RAM via `mem_ack` since session start.
  - Timeout bytes are not included.
  - A read of address `SIZE` returns the checksum, with 1-cycle wait.
- **Not defined:** no checksum register exists, and address `SIZE` returns `8'hFF` like any other out-of-range address.

## Test plan
- **Reset:** assert `reset_n=0` mid-REQ → all outputs 0 immediately (asynchronous); after release, state is IDLE.
- **In-range read:** upload=1, rd addr 0x05, arbiter acks 3 cycles later with 0xA7 → `mem_addr=0x05`, wait high for exactly 3 cycles, `ioctl_din=0xA7`, `mem_req` low on the ack edge.
- **Out-of-range read:** rd addr 0x1234 (SIZE=256) → no `mem_req`, wait high 1 cycle, `ioctl_din=0xFF`.
- **Timeout:** rd addr 0x10 with no ack → after 63 cycles `ioctl_din=0x00`, `timeout_err=1`. The next session start clears `timeout_err`.
- **Upload abort:** drop `ioctl_upload` during REQ → `mem_req` and `ioctl_wait` are 0 at the next edge; a subsequent rd with upload=0 is ignored.
- **Checksum (macro on):** read bytes 0x11, 0x22, 0x44, then rd addr 256 → `ioctl_din=0x77`. With the macro off, the same read returns 0xFF.

Source files
------------

// File: rtl/save_ram_uploader.sv
// Serves HPS upload reads of cartridge RAM through a req/ack arbiter port, stalling the HPS via ioctl_wait.
// Optional macro UPLOAD_CKSUM_EN adds an XOR checksum readable at address SIZE.
module save_ram_uploader #(
  parameter int unsigned AW      = 8,
  parameter int unsigned SIZE    = 256,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IOAW = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          upload_q;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          session_start;
  logic          in_range;
`ifdef UPLOAD_CKSUM_EN
  logic [7:0]    cksum_q, cksum_d;
  logic          cks_sel_q, cks_sel_d;
`endif

  assign session_start = ioctl_upload && !upload_q;
  assign in_range      = (ioctl_addr < IOAW'(SIZE));

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    terr_d  = terr_q;
`ifdef UPLOAD_CKSUM_EN
    cksum_d   = cksum_q;
    cks_sel_d = cks_sel_q;
`endif

    if (session_start) begin
      terr_d = 1'b0;
`ifdef UPLOAD_CKSUM_EN
      cksum_d = 8'h00;
`endif
    end

    if (!ioctl_upload) begin
      // Session dropped: abandon any read, keep last returned byte
      state_d = ST_IDLE;
      cnt_d   = '0;
      wait_d  = 1'b0;
      req_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ioctl_rd) begin
            wait_d = 1'b1;
            busy_d = 1'b1;
            cnt_d  = '0;
            if (in_range) begin
              addr_d  = ioctl_addr[AW-1:0];
              req_d   = 1'b1;
              state_d = ST_REQ;
            end else begin
              state_d = ST_RESP;
`ifdef UPLOAD_CKSUM_EN
              cks_sel_d = (ioctl_addr == IOAW'(SIZE));
`endif
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            din_d   = mem_dout;
`ifdef UPLOAD_CKSUM_EN
            cksum_d = cksum_q ^ mem_dout;
`endif
            state_d = ST_IDLE;
            req_d   = 1'b0;
            wait_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            din_d   = 8'h00;
            terr_d  = 1'b1;
            state_d = ST_IDLE;
            req_d   = 1'b0;
            wait_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
`ifdef UPLOAD_CKSUM_EN
          din_d = cks_sel_q ? cksum_q : 8'hFF;
`else
          din_d = 8'hFF;
`endif
          state_d = ST_IDLE;
          wait_d  = 1'b0;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
          req_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      upload_q <= 1'b0;
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
`ifdef UPLOAD_CKSUM_EN
      cksum_q   <= 8'h00;
      cks_sel_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      upload_q <= ioctl_upload;
      din_q    <= din_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
`ifdef UPLOAD_CKSUM_EN
      cksum_q   <= cksum_d;
      cks_sel_q <= cks_sel_d;
`endif
    end
  end

  assign ioctl_din   = din_q;
  assign ioctl_wait  = wait_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule
